// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter: round-robin arbiter for the single GPR write port between ALU and load writeback,
// with a drain/clear sequence that keeps the clear strobe apart from any write.
module gpr_wb_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              i_req0_valid,
    input  logic [ADDR_W-1:0] i_req0_dest,
    input  logic [DATA_W-1:0] i_req0_data,
    output logic              o_req0_ready,
    input  logic              i_req1_valid,
    input  logic [ADDR_W-1:0] i_req1_dest,
    input  logic [DATA_W-1:0] i_req1_data,
    output logic              o_req1_ready,
    input  logic              i_clr_req,
    output logic              o_reg_write_en,
    output logic [ADDR_W-1:0] o_reg_write_dest,
    output logic [DATA_W-1:0] o_reg_write_data,
    output logic              o_gpr_clr,
    output logic              o_busy
);
    typedef enum logic [1:0] {ARB, DRAIN, CLEAR} state_t;
    state_t r_state;
    logic   r_last_grant;
    logic   w_arb;
    logic   w_xfer;
    // grants only open in ARB with no clear pending; r_last_grant=1 favours req0 on a tie
    assign w_arb        = clr_n && r_state == ARB && !i_clr_req;
    assign o_req0_ready = w_arb && i_req0_valid && (!i_req1_valid || r_last_grant);
    assign o_req1_ready = w_arb && i_req1_valid && (!i_req0_valid || !r_last_grant);
    assign w_xfer       = o_req0_ready || o_req1_ready;
    assign o_busy       = r_state != ARB;
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_state          <= ARB;
            r_last_grant     <= 1'b1;
            o_reg_write_en   <= 1'b0;
            o_reg_write_dest <= '0;
            o_reg_write_data <= '0;
            o_gpr_clr        <= 1'b0;
        end else begin
            o_reg_write_en <= w_xfer;
            o_gpr_clr      <= r_state == DRAIN;
            if (w_xfer) begin
                r_last_grant     <= o_req1_ready;
                o_reg_write_dest <= o_req1_ready ? i_req1_dest : i_req0_dest;
                o_reg_write_data <= o_req1_ready ? i_req1_data : i_req0_data;
            end
            r_state <= r_state == ARB   ? (i_clr_req ? DRAIN : ARB) :
                       r_state == DRAIN ? CLEAR : ARB;
        end
    end
endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// tb_gpr_wb_arbiter: directed vectors with hand-computed expectations for the GPR writeback arbiter.
module tb_gpr_wb_arbiter;
    logic        clk = 1'b0;
    logic        clr_n;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [2:0]  req0_dest, req1_dest, wr_dest;
    logic [15:0] req0_data, req1_data, wr_data;
    logic        clr_req, wr_en, gpr_clr, busy;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    gpr_wb_arbiter #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk(clk), .clr_n(clr_n),
        .i_req0_valid(req0_valid), .i_req0_dest(req0_dest), .i_req0_data(req0_data), .o_req0_ready(req0_ready),
        .i_req1_valid(req1_valid), .i_req1_dest(req1_dest), .i_req1_data(req1_data), .o_req1_ready(req1_ready),
        .i_clr_req(clr_req), .o_reg_write_en(wr_en), .o_reg_write_dest(wr_dest), .o_reg_write_data(wr_data),
        .o_gpr_clr(gpr_clr), .o_busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // advance one edge and settle 1 time unit past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr_n = 1'b0; clr_req = 1'b0;
        req0_valid = 1'b1; req0_dest = 3'd1; req0_data = 16'h1111;
        req1_valid = 1'b1; req1_dest = 3'd2; req1_data = 16'h2222;
        tick(); tick();
        check("rst_rdy0", req0_ready, 0);
        check("rst_rdy1", req1_ready, 0);
        check("rst_we", wr_en, 0);
        check("rst_clr", gpr_clr, 0);
        check("rst_busy", busy, 0);
        check("rst_dest", wr_dest, 0);
        check("rst_data", wr_data, 0);

        clr_n = 1'b1; req1_valid = 1'b0;
        req0_dest = 3'd3; req0_data = 16'hABCD;
        #1;
        check("t2_rdy0", req0_ready, 1);
        check("t2_rdy1", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        check("t2_we", wr_en, 1);
        check("t2_dest", wr_dest, 3);
        check("t2_data", wr_data, 16'hABCD);
        tick();
        check("t2_we_off", wr_en, 0);
        check("t2_dest_hold", wr_dest, 3);
        check("t2_data_hold", wr_data, 16'hABCD);

        clr_n = 1'b0;
        tick();
        clr_n = 1'b1;
        req0_valid = 1'b1; req0_dest = 3'd1; req0_data = 16'h1111;
        req1_valid = 1'b1; req1_dest = 3'd2; req1_data = 16'h2222;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t3_rdy0", req0_ready, (i % 2) == 0);
            check("t3_rdy1", req1_ready, (i % 2) == 1);
            tick();
            check("t3_we", wr_en, 1);
            check("t3_dest", wr_dest, (i % 2) ? 2 : 1);
            check("t3_data", wr_data, (i % 2) ? 16'h2222 : 16'h1111);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        check("t3_we_off", wr_en, 0);

        req1_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req1_dest = 3'(4 + i); req1_data = 16'h3000 + 16'(i);
            #1;
            check("t4_rdy1", req1_ready, 1);
            check("t4_rdy0", req0_ready, 0);
            tick();
            check("t4_we", wr_en, 1);
            check("t4_dest", wr_dest, 4 + i);
            check("t4_data", wr_data, 16'h3000 + i);
        end
        req1_valid = 1'b0;

        req0_valid = 1'b1; req0_dest = 3'd5; req0_data = 16'h5555;
        #1;
        check("t5_rdy0", req0_ready, 1);
        tick();
        clr_req = 1'b1; req0_dest = 3'd6; req0_data = 16'h6666;
        #1;
        check("t5_req_rdy0", req0_ready, 0);
        check("t5_req_rdy1", req1_ready, 0);
        check("t5_req_we", wr_en, 1);
        check("t5_req_dest", wr_dest, 5);
        check("t5_req_data", wr_data, 16'h5555);
        check("t5_req_busy", busy, 0);
        tick();
        clr_req = 1'b0;
        #1;
        check("t5_drain_busy", busy, 1);
        check("t5_drain_we", wr_en, 0);
        check("t5_drain_clr", gpr_clr, 0);
        check("t5_drain_rdy0", req0_ready, 0);
        tick();
        check("t5_clear_clr", gpr_clr, 1);
        check("t5_clear_busy", busy, 1);
        check("t5_clear_we", wr_en, 0);
        check("t5_clear_rdy0", req0_ready, 0);
        tick();
        check("t5_arb_clr", gpr_clr, 0);
        check("t5_arb_busy", busy, 0);
        check("t5_arb_rdy0", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        check("t5_resume_we", wr_en, 1);
        check("t5_resume_dest", wr_dest, 6);
        check("t5_resume_data", wr_data, 16'h6666);

        req1_valid = 1'b1; req1_dest = 3'd7; req1_data = 16'h7777;
        #1;
        check("t6_rdy1", req1_ready, 1);
        tick();
        req1_valid = 1'b0; clr_n = 1'b0;
        #1;
        check("t6_rst_rdy1", req1_ready, 0);
        check("t6_pre_we", wr_en, 1);
        tick();
        check("t6_rst_we", wr_en, 0);
        check("t6_rst_dest", wr_dest, 0);
        check("t6_rst_data", wr_data, 0);
        clr_n = 1'b1;
        tick();
        check("t6_rel_we", wr_en, 0);
        tick();
        check("t6_rel_we2", wr_en, 0);
        check("t6_rel_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
